// File: rtl/bist_tpg_pkg.sv
// -----------------------------------------------------------------------------
// bist_tpg_pkg
// Shared definitions for the BIST LFSR test-pattern generator:
//   - tpg_state_e   : run-control FSM states (IDLE / RUN / DONE)
//   - lfsr_vec_t    : width-agnostic LFSR vector (widths up to LFSR_MAX_W)
//   - POLY_Wn       : maximal-length Fibonacci tap masks for widths 3..16
//   - default_poly  : lookup of the above by width
//   - lfsr_next     : one Fibonacci step, with optional all-zero insertion
// Tap mask convention: bit i set means stage i+1 feeds the XOR.
// -----------------------------------------------------------------------------
package bist_tpg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tpg_state_e;

    localparam int unsigned LFSR_MAX_W = 32;
    typedef logic [LFSR_MAX_W-1:0] lfsr_vec_t;

    localparam lfsr_vec_t LFSR_ONE  = {{(LFSR_MAX_W-1){1'b0}}, 1'b1};
    localparam lfsr_vec_t LFSR_ZERO = {LFSR_MAX_W{1'b0}};

    localparam lfsr_vec_t POLY_W3  = 32'h0000_0006;
    localparam lfsr_vec_t POLY_W4  = 32'h0000_000C;
    localparam lfsr_vec_t POLY_W5  = 32'h0000_0014;
    localparam lfsr_vec_t POLY_W6  = 32'h0000_0030;
    localparam lfsr_vec_t POLY_W7  = 32'h0000_0060;
    localparam lfsr_vec_t POLY_W8  = 32'h0000_00B8;
    localparam lfsr_vec_t POLY_W9  = 32'h0000_0110;
    localparam lfsr_vec_t POLY_W10 = 32'h0000_0240;
    localparam lfsr_vec_t POLY_W11 = 32'h0000_0500;
    localparam lfsr_vec_t POLY_W12 = 32'h0000_0E08;
    localparam lfsr_vec_t POLY_W13 = 32'h0000_1C80;
    localparam lfsr_vec_t POLY_W14 = 32'h0000_3802;
    localparam lfsr_vec_t POLY_W15 = 32'h0000_6000;
    localparam lfsr_vec_t POLY_W16 = 32'h0000_D008;

    // Maximal-length tap mask for a given width; zero for unsupported widths.
    function automatic lfsr_vec_t default_poly(input int unsigned width);
        lfsr_vec_t poly;
        case (width)
            32'd3:   poly = POLY_W3;
            32'd4:   poly = POLY_W4;
            32'd5:   poly = POLY_W5;
            32'd6:   poly = POLY_W6;
            32'd7:   poly = POLY_W7;
            32'd8:   poly = POLY_W8;
            32'd9:   poly = POLY_W9;
            32'd10:  poly = POLY_W10;
            32'd11:  poly = POLY_W11;
            32'd12:  poly = POLY_W12;
            32'd13:  poly = POLY_W13;
            32'd14:  poly = POLY_W14;
            32'd15:  poly = POLY_W15;
            32'd16:  poly = POLY_W16;
            default: poly = LFSR_ZERO;
        endcase
        return poly;
    endfunction

    // One shift-left Fibonacci step on the low 'width' bits of 'state'.
    // In de Bruijn mode the feedback is inverted whenever the bits about to
    // remain (all but the MSB) are zero: this splices 0...0 in after 10...0
    // and leaves it again towards 0...01, giving a 2^width cycle.
    function automatic lfsr_vec_t lfsr_next(input lfsr_vec_t   state,
                                            input lfsr_vec_t   poly,
                                            input logic        zero_en,
                                            input int unsigned width);
        lfsr_vec_t low_mask;
        lfsr_vec_t full_mask;
        logic      low_zero;
        logic      fb;
        low_mask  = (LFSR_ONE << (width - 32'd1)) - LFSR_ONE;
        full_mask = (low_mask << 1) | LFSR_ONE;
        low_zero  = ((state & low_mask) == LFSR_ZERO);
        fb        = (^(state & poly)) ^ (zero_en & low_zero);
        return ((state << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & full_mask;
    endfunction

endpackage

// File: rtl/bist_lfsr_core.sv
// -----------------------------------------------------------------------------
// bist_lfsr_core
// LFSR state register plus step logic.
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset (state -> 0...01)
//   load       : load load_value this cycle (has priority over enable)
//   load_value : value to load
//   enable     : advance one LFSR step
//   zero_en    : de Bruijn mode for the step function
//   state      : current LFSR contents
// -----------------------------------------------------------------------------
module bist_lfsr_core
    import bist_tpg_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'hB8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             zero_en,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] STATE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] next_s;

    assign next_s = WIDTH'(lfsr_next(lfsr_vec_t'(state_r), lfsr_vec_t'(POLY), zero_en, WIDTH));

    // LFSR state register: load wins over step, otherwise hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= STATE_ONE;
        end else if (load) begin
            state_r <= load_value;
        end else if (enable) begin
            state_r <= next_s;
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/bist_lfsr_tpg.sv
// -----------------------------------------------------------------------------
// bist_lfsr_tpg
// LFSR test-pattern generator with run control for the BIST datapath.
//   clock         : rising-edge clock
//   reset         : asynchronous active-low reset
//   start         : request a run (accepted in IDLE or DONE)
//   hold          : stall LFSR, counter and FSM while running
//   seed          : seed captured on an accepted start
//   num_patterns  : patterns per run, 0 = full period
//   zero_en       : de Bruijn mode, captured on an accepted start
//   data_out      : current test pattern
//   pattern_valid : data_out is a live pattern this cycle
//   busy          : run in progress
//   complete      : run finished (level, held in DONE)
//   seed_fix      : last start had a zero seed replaced by 0...01
// -----------------------------------------------------------------------------
module bist_lfsr_tpg
    import bist_tpg_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'hB8,
    parameter int unsigned      CNT_W = WIDTH + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic             zero_en,
    output logic [WIDTH-1:0] data_out,
    output logic             pattern_valid,
    output logic             busy,
    output logic             complete,
    output logic             seed_fix
);

    localparam logic [WIDTH-1:0] SEED_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SEED_ZERO   = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TARGET_FULL = CNT_ONE << WIDTH;
    localparam logic [CNT_W-1:0] TARGET_NZ   = TARGET_FULL - CNT_ONE;

    tpg_state_e       state_r;
    tpg_state_e       state_next_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] target_r;
    logic [CNT_W-1:0] target_s;
    logic             mode_r;
    logic             seed_fix_r;
    logic             busy_r;
    logic             complete_r;
    logic             accept_s;
    logic             step_s;
    logic             last_s;
    logic             seed_zero_s;
    logic [WIDTH-1:0] load_value_s;

    assign accept_s    = start && (state_r != ST_RUN);
    assign step_s      = (state_r == ST_RUN) && !hold;
    assign last_s      = (count_r == (target_r - CNT_ONE));
    assign seed_zero_s = (seed == SEED_ZERO) && !zero_en;

    // Start-time decode: seed substitution and run length.
    always_comb begin
        load_value_s = seed;
        target_s     = num_patterns;
        if (seed_zero_s) begin
            load_value_s = SEED_ONE;
        end else begin
            load_value_s = seed;
        end
        if (num_patterns != CNT_ZERO) begin
            target_s = num_patterns;
        end else if (zero_en) begin
            target_s = TARGET_FULL;
        end else begin
            target_s = TARGET_NZ;
        end
    end

    // Next-state logic for the run-control FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RUN: begin
                if (step_s && last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register with registered busy/complete decodes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            complete_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            busy_r     <= (state_next_s == ST_RUN);
            complete_r <= (state_next_s == ST_DONE);
        end
    end

    // Run parameters captured on an accepted start; pattern counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r    <= CNT_ZERO;
            target_r   <= CNT_ZERO;
            mode_r     <= 1'b0;
            seed_fix_r <= 1'b0;
        end else if (accept_s) begin
            count_r    <= CNT_ZERO;
            target_r   <= target_s;
            mode_r     <= zero_en;
            seed_fix_r <= seed_zero_s;
        end else if (step_s) begin
            count_r    <= count_r + CNT_ONE;
            target_r   <= target_r;
            mode_r     <= mode_r;
            seed_fix_r <= seed_fix_r;
        end else begin
            count_r    <= count_r;
            target_r   <= target_r;
            mode_r     <= mode_r;
            seed_fix_r <= seed_fix_r;
        end
    end

    // The final pattern is not stepped past, so DONE keeps showing it.
    bist_lfsr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .load       (accept_s),
        .load_value (load_value_s),
        .enable     (step_s && !last_s),
        .zero_en    (mode_r),
        .state      (data_out)
    );

    assign pattern_valid = busy_r && !hold;
    assign busy          = busy_r;
    assign complete      = complete_r;
    assign seed_fix      = seed_fix_r;

endmodule

// File: tb/tb_bist_lfsr_tpg.sv
module tb_bist_lfsr_tpg;

    logic       clock;
    logic       reset;

    // 3-bit instance
    logic       start3;
    logic       hold3;
    logic [2:0] seed3;
    logic [3:0] np3;
    logic       zen3;
    logic [2:0] data3;
    logic       pv3;
    logic       busy3;
    logic       cmp3;
    logic       fix3;

    // 8-bit default instance
    logic       start8;
    logic       hold8;
    logic [7:0] seed8;
    logic [8:0] np8;
    logic       zen8;
    logic [7:0] data8;
    logic       pv8;
    logic       busy8;
    logic       cmp8;
    logic       fix8;

    int n_tests;
    int n_fail;

    logic [2:0] exp3 [16];
    logic       seen [256];

    bist_lfsr_tpg #(
        .WIDTH (3),
        .POLY  (3'b110),
        .CNT_W (4)
    ) dut3 (
        .clock         (clock),
        .reset         (reset),
        .start         (start3),
        .hold          (hold3),
        .seed          (seed3),
        .num_patterns  (np3),
        .zero_en       (zen3),
        .data_out      (data3),
        .pattern_valid (pv3),
        .busy          (busy3),
        .complete      (cmp3),
        .seed_fix      (fix3)
    );

    bist_lfsr_tpg dut8 (
        .clock         (clock),
        .reset         (reset),
        .start         (start8),
        .hold          (hold8),
        .seed          (seed8),
        .num_patterns  (np8),
        .zero_en       (zen8),
        .data_out      (data8),
        .pattern_valid (pv8),
        .busy          (busy8),
        .complete      (cmp8),
        .seed_fix      (fix8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load_nz;
        exp3[0] = 3'b001; exp3[1] = 3'b010; exp3[2] = 3'b101; exp3[3] = 3'b011;
        exp3[4] = 3'b111; exp3[5] = 3'b110; exp3[6] = 3'b100; exp3[7] = 3'b001;
        exp3[8] = 3'b010;
    endtask

    // Run the 3-bit DUT against exp3[0..n-1]; optional hold burst before
    // pattern hold_at and an ignored start request during pattern ign_at.
    task automatic run3(input string name, input logic [2:0] sd, input logic zen,
                        input logic [3:0] np, input int n, input int hold_at,
                        input int hold_len, input int ign_at, input logic exp_fix);
        seed3 = sd; zen3 = zen; np3 = np; start3 = 1'b1;
        tick;
        start3 = 1'b0;
        check({name, " seed_fix"}, 32'(fix3), 32'(exp_fix));
        for (int i = 0; i < n; i++) begin
            if (i == hold_at) begin
                for (int h = 0; h < hold_len; h++) begin
                    hold3 = 1'b1;
                    #1;
                    check({name, " hold pv"}, 32'(pv3), 32'd0);
                    check({name, " hold data"}, 32'(data3), 32'(exp3[i]));
                    check({name, " hold busy"}, 32'(busy3), 32'd1);
                    tick;
                end
                hold3 = 1'b0;
                #1;
            end
            check({name, " pv"}, 32'(pv3), 32'd1);
            check({name, " data"}, 32'(data3), 32'(exp3[i]));
            check({name, " complete low"}, 32'(cmp3), 32'd0);
            if (i == ign_at) begin
                start3 = 1'b1;
                seed3  = 3'b111;
            end
            tick;
            start3 = 1'b0;
        end
        check({name, " complete"}, 32'(cmp3), 32'd1);
        check({name, " done pv"}, 32'(pv3), 32'd0);
        check({name, " done busy"}, 32'(busy3), 32'd0);
        check({name, " done data"}, 32'(data3), 32'(exp3[n-1]));
    endtask

    initial begin
        logic [7:0] m;
        int distinct;
        n_tests = 0;
        n_fail  = 0;
        reset  = 1'b0;
        start3 = 1'b0; hold3 = 1'b0; seed3 = 3'b000; np3 = 4'd0; zen3 = 1'b0;
        start8 = 1'b0; hold8 = 1'b0; seed8 = 8'h00; np8 = 9'd0; zen8 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst data3", 32'(data3), 32'd1);
        check("rst pv3", 32'(pv3), 32'd0);
        check("rst busy3", 32'(busy3), 32'd0);
        check("rst cmp3", 32'(cmp3), 32'd0);
        check("rst fix3", 32'(fix3), 32'd0);
        check("rst data8", 32'(data8), 32'd1);
        reset = 1'b1;
        tick;

        // hold outside RUN has no effect on a start
        load_nz();
        hold3 = 1'b1;
        tick;
        hold3 = 1'b0;
        run3("full7", 3'b001, 1'b0, 4'd0, 7, -1, 0, -1, 1'b0);

        // de Bruijn: all eight codes, zero last
        load_nz();
        exp3[7] = 3'b000;
        run3("debruijn", 3'b001, 1'b1, 4'd0, 8, -1, 0, -1, 1'b0);

        // zero seed substituted, short run, start in RUN ignored
        load_nz();
        run3("zeroseed", 3'b000, 1'b0, 4'd3, 3, -1, 0, 1, 1'b1);

        // hold burst of 4 on the 2nd pattern
        load_nz();
        run3("hold", 3'b001, 1'b0, 4'd0, 7, 1, 4, -1, 1'b0);

        // count beyond the period wraps the sequence
        load_nz();
        run3("wrap", 3'b001, 1'b0, 4'd9, 9, -1, 0, -1, 1'b0);

        // mid-run reset at the 3rd pattern
        seed3 = 3'b000; zen3 = 1'b0; np3 = 4'd0; start3 = 1'b1;
        tick;
        start3 = 1'b0;
        tick;
        tick;
        check("mid data", 32'(data3), 32'd5);
        reset = 1'b0;
        #1;
        check("arst data", 32'(data3), 32'd1);
        check("arst pv", 32'(pv3), 32'd0);
        check("arst busy", 32'(busy3), 32'd0);
        check("arst cmp", 32'(cmp3), 32'd0);
        check("arst fix", 32'(fix3), 32'd0);
        reset = 1'b1;
        tick;
        check("post rst cmp", 32'(cmp3), 32'd0);
        load_nz();
        run3("after rst", 3'b001, 1'b0, 4'd0, 7, -1, 0, -1, 1'b0);

        // restart from DONE
        seed3 = 3'b101; start3 = 1'b1;
        tick;
        start3 = 1'b0;
        check("restart data", 32'(data3), 32'd5);
        check("restart cmp", 32'(cmp3), 32'd0);
        check("restart pv", 32'(pv3), 32'd1);
        repeat (7) tick;
        check("restart complete", 32'(cmp3), 32'd1);

        // 8-bit full period against a reference model
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        distinct = 0;
        m = 8'h01;
        seed8 = 8'h01; np8 = 9'd0; zen8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        for (int i = 0; i < 255; i++) begin
            check("w8 pv", 32'(pv8), 32'd1);
            check("w8 data", 32'(data8), 32'(m));
            check("w8 repeat", 32'(seen[data8]), 32'd0);
            if (!seen[data8]) distinct++;
            seen[data8] = 1'b1;
            m = {m[6:0], ^(m & 8'hB8)};
            tick;
        end
        check("w8 distinct", 32'(distinct), 32'd255);
        check("w8 zero unseen", 32'(seen[0]), 32'd0);
        check("w8 period", 32'(m), 32'd1);
        check("w8 complete", 32'(cmp8), 32'd1);
        check("w8 done pv", 32'(pv8), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
